transposed_buffer_sequencer: RTL and testbench

//   Control and read-out stage wrapped around the 9x4 transposed buffer in the interpolation datapath.
//   - Accepts rows of COLS samples from the horizontal stage and drives the buffer's WRITE_EN.
//   - Once ROWS rows are written, streams the buffer's COLS columns to the vertical filter,
//     one column per handshake.
//   - Holds off upstream while draining, so the buffer contents stay frozen during read-out.

---
 rtl/transposed_buffer_sequencer.sv | 100 ++++++++++
 tb/tb_transposed_buffer_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transposed_buffer_sequencer.sv
// Fill/drain sequencer for the 9x4 transposed buffer.
// Writes ROWS rows, then streams COLS columns downstream.
module transposed_buffer_sequencer #(
  parameter int SAMPLE_W = 11,
  parameter int ROWS     = 9,
  parameter int COLS     = 4
) (
  input  logic                            CLK,
  input  logic                            RST_SYNC,
  input  logic                            FLUSH,
  input  logic                            ROW_VALID,
  output logic                            ROW_READY,
  output logic                            WRITE_EN,
  input  logic [COLS*ROWS*SAMPLE_W-1:0]   COLS_IN,
  output logic [ROWS*SAMPLE_W-1:0]        COL_OUT,
  output logic [$clog2(COLS)-1:0]         COL_IDX,
  output logic                            COL_VALID,
  input  logic                            COL_READY,
  output logic                            COL_LAST,
  output logic                            BLOCK_DONE
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int COL_W = ROWS * SAMPLE_W;

  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_END = CW'(COLS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          draining;
  logic          col_fire;

  assign draining  = (state == DRAIN);
  assign ROW_READY = ~draining;
  assign WRITE_EN  = ROW_VALID & ROW_READY
                   & ~FLUSH & ~RST_SYNC;

  assign COL_VALID = draining;
  assign COL_IDX   = draining ? col_cnt : '0;
  assign COL_LAST  = draining & (col_cnt == COL_END);
  assign col_fire  = COL_VALID & COL_READY;

  // Column mux; zeroed outside DRAIN
  always_comb begin
    COL_OUT = '0;
    if (draining)
      COL_OUT = COLS_IN[col_cnt*COL_W +: COL_W];
  end

  // FILL/DRAIN sequencing, counters and done pulse
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state      <= FILL;
      row_cnt    <= '0;
      col_cnt    <= '0;
      BLOCK_DONE <= 1'b0;
    end else begin
      BLOCK_DONE <= 1'b0;
      if (FLUSH) begin
        state   <= FILL;
        row_cnt <= '0;
        col_cnt <= '0;
      end else begin
        unique case (state)
          FILL: begin
            if (WRITE_EN) begin
              if (row_cnt == ROW_END) begin
                row_cnt <= '0;
                col_cnt <= '0;
                state   <= DRAIN;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (col_fire) begin
              if (col_cnt == COL_END) begin
                col_cnt    <= '0;
                state      <= FILL;
                BLOCK_DONE <= 1'b1;
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_transposed_buffer_sequencer.sv
// Directed bench for transposed_buffer_sequencer.
// Includes a behavioural model of the external shift buffer.
module tb_transposed_buffer_sequencer;

  localparam int SW    = 11;
  localparam int ROWS  = 9;
  localparam int COLS  = 4;
  localparam int COL_W = ROWS * SW;
  localparam int ROW_W = COLS * SW;

  logic                    CLK;
  logic                    RST_SYNC;
  logic                    FLUSH;
  logic                    ROW_VALID;
  logic                    ROW_READY;
  logic                    WRITE_EN;
  logic [COLS*COL_W-1:0]   COLS_IN;
  logic [COL_W-1:0]        COL_OUT;
  logic [1:0]              COL_IDX;
  logic                    COL_VALID;
  logic                    COL_READY;
  logic                    COL_LAST;
  logic                    BLOCK_DONE;

  int checks = 0;
  int errors = 0;

  logic [ROW_W-1:0] row_data;
  logic [ROW_W-1:0] buff [ROWS];

  transposed_buffer_sequencer #(
    .SAMPLE_W(SW), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .CLK(CLK),
    .RST_SYNC(RST_SYNC),
    .FLUSH(FLUSH),
    .ROW_VALID(ROW_VALID),
    .ROW_READY(ROW_READY),
    .WRITE_EN(WRITE_EN),
    .COLS_IN(COLS_IN),
    .COL_OUT(COL_OUT),
    .COL_IDX(COL_IDX),
    .COL_VALID(COL_VALID),
    .COL_READY(COL_READY),
    .COL_LAST(COL_LAST),
    .BLOCK_DONE(BLOCK_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shift buffer: newest row at the top slot
  always @(posedge CLK) begin
    if (WRITE_EN) begin
      for (int r = 0; r < ROWS - 1; r++)
        buff[r] <= buff[r+1];
      buff[ROWS-1] <= row_data;
    end
  end

  always_comb begin
    COLS_IN = '0;
    for (int k = 0; k < COLS; k++)
      for (int r = 0; r < ROWS; r++)
        COLS_IN[(k*ROWS+r)*SW +: SW] = buff[r][k*SW +: SW];
  end

  typedef struct {
    logic       rst;
    logic       flush;
    logic       rv;
    logic       cr;
    int         row;
    logic       rr;
    logic       we;
    logic       cv;
    logic [1:0] idx;
    logic       last;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl,
                       input logic rv, input logic cr);
    RST_SYNC  = rst;
    FLUSH     = fl;
    ROW_VALID = rv;
    COL_READY = cr;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_row(input int base);
    for (int c = 0; c < COLS; c++)
      row_data[c*SW +: SW] = SW'(base + c);
  endtask

  function automatic logic [COL_W-1:0] exp_col(input int k);
    logic [COL_W-1:0] res;
    for (int r = 0; r < ROWS; r++)
      res[r*SW +: SW] = SW'(4*r + k);
    return res;
  endfunction

  task automatic do_reset;
    drive(1, 0, 0, 0);
    tick();
  endtask

  task automatic fill_rows(input int base0);
    for (int r = 0; r < ROWS; r++) begin
      set_row(base0 + 4*r);
      drive(0, 0, 1, 0);
      chk("fill_we", WRITE_EN, 1);
      tick();
    end
  endtask

  int we_n;
  int done_n;
  int done_at [3];

  initial begin
    RST_SYNC  = 1;
    FLUSH     = 0;
    ROW_VALID = 0;
    COL_READY = 0;
    row_data  = '0;
    tick();

    // Test 1: one complete block, table driven
    tbl[0] = '{1,0,0,0,0, 1,0,0,2'd0,0,0};
    for (int i = 1; i <= ROWS; i++)
      tbl[i] = '{0,0,1,1,i-1, 1,1,0,2'd0,0,0};
    for (int k = 0; k < COLS; k++)
      tbl[10+k] = '{0,0,1,1,0, 0,0,1,2'(k),
                    (k == COLS-1),0};
    tbl[14] = '{0,0,0,1,0, 1,0,0,2'd0,0,1};
    tbl[15] = '{0,0,0,0,0, 1,0,0,2'd0,0,0};

    for (int i = 0; i < 16; i++) begin
      set_row(4*tbl[i].row);
      drive(tbl[i].rst, tbl[i].flush,
            tbl[i].rv, tbl[i].cr);
      chk("t1_row_ready", ROW_READY, tbl[i].rr);
      chk("t1_write_en", WRITE_EN, tbl[i].we);
      chk("t1_col_valid", COL_VALID, tbl[i].cv);
      chk("t1_col_idx", COL_IDX, tbl[i].idx);
      chk("t1_col_last", COL_LAST, tbl[i].last);
      chk("t1_block_done", BLOCK_DONE, tbl[i].done);
      if (tbl[i].cv)
        chk("t1_col_out", COL_OUT, exp_col(int'(tbl[i].idx)));
      else
        chk("t1_col_out_zero", COL_OUT, 0);
      if (i == 10) begin
        chk("t1_col0_ls", COL_OUT[SW-1:0], 0);
        chk("t1_col0_ms", COL_OUT[COL_W-1 -: SW], 32);
      end
      tick();
    end

    // Test 2: backpressure on column 2
    do_reset();
    for (int r = 0; r < ROWS; r++) begin
      set_row(4*r);
      drive(0, 0, 1, 1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 1);
      chk("t2_pre_idx", COL_IDX, k);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 1, (j == 3));
      chk("t2_hold_valid", COL_VALID, 1);
      chk("t2_hold_idx", COL_IDX, 2);
      chk("t2_hold_out", COL_OUT, exp_col(2));
      chk("t2_hold_rr", ROW_READY, 0);
      chk("t2_hold_we", WRITE_EN, 0);
      tick();
    end
    drive(0, 0, 1, 1);
    chk("t2_idx3", COL_IDX, 3);
    chk("t2_last", COL_LAST, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t2_done", BLOCK_DONE, 1);
    tick();

    // Test 3: signed extreme passes through unchanged
    do_reset();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++)
        row_data[c*SW +: SW] = 11'h400;
      drive(0, 0, 1, 0);
      tick();
    end
    for (int k = 0; k < COLS; k++) begin
      drive(0, 0, 0, 1);
      chk("t3_idx", COL_IDX, k);
      chk("t3_out", COL_OUT, {ROWS{11'h400}});
      tick();
    end

    // Test 4: flush after 5 rows, then a fresh block
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_row(100 + 4*r);
      drive(0, 0, 1, 0);
      tick();
    end
    set_row(200);
    drive(0, 1, 1, 0);
    chk("t4_flush_we", WRITE_EN, 0);
    chk("t4_flush_done", BLOCK_DONE, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_post_done", BLOCK_DONE, 0);
    chk("t4_post_rr", ROW_READY, 1);
    fill_rows(0);
    for (int k = 0; k < COLS; k++) begin
      drive(0, 0, 0, 1);
      chk("t4_cv", COL_VALID, 1);
      chk("t4_out", COL_OUT, exp_col(k));
      chk("t4_nodone", BLOCK_DONE, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("t4_done", BLOCK_DONE, 1);
    tick();

    // Test 5: reset while column 1 pending
    do_reset();
    fill_rows(0);
    drive(0, 0, 0, 1);
    chk("t5_idx0", COL_IDX, 0);
    tick();
    drive(1, 0, 0, 0);
    chk("t5_pend_cv", COL_VALID, 1);
    chk("t5_pend_idx", COL_IDX, 1);
    tick();
    drive(0, 0, 0, 1);
    chk("t5_cv", COL_VALID, 0);
    chk("t5_out", COL_OUT, 0);
    chk("t5_rr", ROW_READY, 1);
    chk("t5_idx", COL_IDX, 0);
    chk("t5_done", BLOCK_DONE, 0);
    for (int r = 0; r < ROWS; r++) begin
      set_row(4*r);
      drive(0, 0, 1, 0);
      chk("t5_refill_rr", ROW_READY, 1);
      tick();
    end
    drive(0, 0, 1, 0);
    chk("t5_redrain_cv", COL_VALID, 1);
    chk("t5_redrain_idx", COL_IDX, 0);
    chk("t5_redrain_out", COL_OUT, exp_col(0));
    tick();

    // Test 6: back-to-back blocks, 13-cycle period
    do_reset();
    we_n   = 0;
    done_n = 0;
    set_row(0);
    for (int c = 0; c < 40; c++) begin
      drive(0, 0, 1, 1);
      chk("t6_overlap", WRITE_EN & COL_VALID, 0);
      if (WRITE_EN) we_n++;
      if (BLOCK_DONE) begin
        if (done_n < 3) done_at[done_n] = c;
        done_n++;
      end
      tick();
    end
    chk("t6_we_count", we_n, 28);
    chk("t6_done_count", done_n, 3);
    chk("t6_first_done", done_at[0], 13);
    chk("t6_period_a", done_at[1] - done_at[0], 13);
    chk("t6_period_b", done_at[2] - done_at[1], 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
